// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// default operand width and a counter-width helper.
package serial_sub_pkg;

  // Default operand/result width in bits (must be at least 2).
  localparam int unsigned SERIAL_SUB_WIDTH = 8;

  // Controller states. Encodings are fixed so that waveforms and any
  // legacy tooling that decodes the raw state bits stay stable.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Width of the bit counter. It only needs to reach WIDTH-1, so
  // $clog2(WIDTH) bits suffice; clamp to one bit for degenerate widths.
  function automatic int unsigned cnt_bits(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage : serial_sub_pkg

// File: rtl/full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = a - b - bin, with the
// borrow produced when a < b + bin.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and outgoing borrow of one bit position.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = x - y - borrow_in, one bit per
// clock, LSB first, through a single full_subtractor cell and a borrow
// flip-flop. Start/ready/valid handshake; all outputs are registered.
//
// Optional feature: define SERIAL_SUB_FLAGS_EN to add the signed-overflow
// and zero flags, latched together with diff.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             borrow_in,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             overflow,
  output logic             zero
`endif
);

  localparam int unsigned CNT_W = cnt_bits(WIDTH);
  // The partial-result register holds the WIDTH-1 low difference bits;
  // the final (MSB) bit goes straight from the cell into the output
  // register on the last shift, so no bit of the shift register is dead.
  localparam int unsigned RES_W = WIDTH - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Control state
  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;

  // Serial datapath
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Output registers
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

`ifdef SERIAL_SUB_FLAGS_EN
  logic             x_msb_q, x_msb_d;
  logic             y_msb_q, y_msb_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
`endif

  // Single shared 1-bit cell operating on the current LSBs.
  logic cell_d;
  logic cell_bout;

  full_subtractor u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Next-state and datapath update logic for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned; a missing default here would infer a latch.
    state_d  = state_q;
    ready_d  = ready_q;
    valid_d  = 1'b0;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_FLAGS_EN
    x_msb_d  = x_msb_q;
    y_msb_d  = y_msb_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = x;
          b_d      = y;
          borrow_d = borrow_in;
          cnt_d    = '0;
          ready_d  = 1'b0;
          state_d  = SHIFT;
`ifdef SERIAL_SUB_FLAGS_EN
          x_msb_d  = x[WIDTH-1];
          y_msb_d  = y[WIDTH-1];
`endif
        end
      end

      SHIFT: begin
        a_d      = {1'b0, a_q[WIDTH-1:1]};
        b_d      = {1'b0, b_q[WIDTH-1:1]};
        res_d    = RES_W'({cell_d, res_q} >> 1);
        borrow_d = cell_bout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the full result in the output register.
          state_d = DONE;
          valid_d = 1'b1;
          diff_d  = {cell_d, res_q};
          bout_d  = cell_bout;
`ifdef SERIAL_SUB_FLAGS_EN
          // Overflow only when operand signs differ and the result sign
          // disagrees with the minuend.
          ovf_d   = (x_msb_q != y_msb_q) && (cell_d != x_msb_q);
          zero_d  = ({cell_d, res_q} == '0);
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_FLAGS_EN
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
`endif
    end
  end

  // Working registers of the serial datapath.
  always_ff @(posedge clk) begin
    // NOTE: these are deliberately not reset; they are always loaded on the
    // accepting edge before being read, so a reset would only cost fan-out.
    a_q      <= a_d;
    b_q      <= b_d;
    res_q    <= res_d;
    borrow_q <= borrow_d;
    cnt_q    <= cnt_d;
`ifdef SERIAL_SUB_FLAGS_EN
    x_msb_q  <= x_msb_d;
    y_msb_q  <= y_msb_d;
`endif
  end

  assign ready      = ready_q;
  assign valid      = valid_q;
  assign diff       = diff_q;
  assign borrow_out = bout_q;
`ifdef SERIAL_SUB_FLAGS_EN
  assign overflow   = ovf_q;
  assign zero       = zero_q;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: a transaction-level reference
// model (plain arithmetic plus a completion-time stamp) is compared against
// every output on every falling edge, and directed cases pin literal results.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         borrow_in;
  logic         ready;
  logic         valid;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUB_FLAGS_EN
  logic         overflow;
  logic         zero;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .x          (x),
    .y          (y),
    .borrow_in  (borrow_in),
    .ready      (ready),
    .valid      (valid),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    .overflow   (overflow),
    .zero       (zero)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    int r;
    r = int'(a) - int'(b) - int'(bi);
    return W'(r);
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    return (int'(a) < int'(b) + int'(bi));
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    int r;
    r = int'($signed(a)) - int'($signed(b)) - int'(bi);
    return (r < -(2 ** (W - 1))) || (r > (2 ** (W - 1)) - 1);
  endfunction

  int           cyc = 0;
  int           m_done_at = 0;
  logic         m_busy = 1'b0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_diff = '0;
  logic         m_bout = 1'b0;
  logic         m_ovf = 1'b0;
  logic         m_zero = 1'b0;
  logic [W-1:0] p_diff = '0;
  logic         p_bout = 1'b0;
  logic         p_ovf = 1'b0;

  // Transaction model: an accepted request completes exactly W edges later,
  // and the unit is busy until one edge after that.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_diff  <= '0;
      m_bout  <= 1'b0;
      m_ovf   <= 1'b0;
      m_zero  <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (m_busy && cyc == m_done_at) begin
        m_valid <= 1'b1;
        m_diff  <= p_diff;
        m_bout  <= p_bout;
        m_ovf   <= p_ovf;
        m_zero  <= (p_diff == '0);
      end else if (m_busy && cyc == m_done_at + 1) begin
        m_busy <= 1'b0;
      end else if (!m_busy && start) begin
        p_diff    <= ref_diff(x, y, borrow_in);
        p_bout    <= ref_borrow(x, y, borrow_in);
        p_ovf     <= ref_ovf(x, y, borrow_in);
        m_busy    <= 1'b1;
        m_done_at <= cyc + W;
      end
    end
    cyc <= cyc + 1;
  end

  // Compare process: every output on every falling edge once reset is seen.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 32'(ready), 32'(!m_busy));
      check("valid", 32'(valid), 32'(m_valid));
      check("diff", 32'(diff), 32'(m_diff));
      check("borrow_out", 32'(borrow_out), 32'(m_bout));
`ifdef SERIAL_SUB_FLAGS_EN
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("zero", 32'(zero), 32'(m_zero));
`endif
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic start_op(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic bv);
    int guard = 0;
    while (!ready && guard < 4 * W) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    x         = xv;
    y         = yv;
    borrow_in = bv;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 4 * W) begin
      @(negedge clk);
      lat++;
      if (valid) break;
    end
    if (!valid) check("valid_timeout", 32'(valid), 32'd1);
  endtask

  task automatic count_valids(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (valid) c++;
    end
  endtask

  task automatic directed(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                          input logic bv, input logic [W-1:0] exp_d, input logic exp_b,
                          input logic exp_o, input logic exp_z);
    int lat;
    start_op(xv, yv, bv);
    wait_valid(lat);
    check({tag, "_latency"}, 32'(lat), 32'(W));
    check({tag, "_diff"}, 32'(diff), 32'(exp_d));
    check({tag, "_borrow"}, 32'(borrow_out), 32'(exp_b));
`ifdef SERIAL_SUB_FLAGS_EN
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_o));
    check({tag, "_zero"}, 32'(zero), 32'(exp_z));
`else
    if (exp_o || exp_z) n_vec += 0;
`endif
    @(negedge clk);
    check({tag, "_ready_after"}, 32'(ready), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int nv;
    logic [W-1:0] xv;
    logic [W-1:0] yv;

    rst_n     = 1'b0;
    start     = 1'b0;
    x         = '0;
    y         = '0;
    borrow_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    directed("100m12",   8'd100, 8'd12,  1'b0, 8'd88,  1'b0, 1'b0, 1'b0);
    directed("99m45b",   8'd99,  8'd45,  1'b1, 8'd53,  1'b0, 1'b0, 1'b0);
    directed("55m127",   8'd55,  8'd127, 1'b0, 8'hB8,  1'b1, 1'b0, 1'b0);
    directed("127m127b", 8'd127, 8'd127, 1'b1, 8'd255, 1'b1, 1'b0, 1'b0);
    directed("127m127",  8'd127, 8'd127, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1);

    // 127 - (-1): start pulsed mid-operation with other operands is ignored.
    start_op(8'd127, 8'd255, 1'b0);
    x     = 8'd5;
    y     = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(lat);
    check("ignore_latency", 32'(lat), 32'(W - 1));
    check("ignore_diff", 32'(diff), 32'd128);
    check("ignore_borrow", 32'(borrow_out), 32'd1);
`ifdef SERIAL_SUB_FLAGS_EN
    check("ignore_ovf", 32'(overflow), 32'd1);
`endif
    count_valids(W + 3, nv);
    check("ignore_single_valid", 32'(nv), 32'd0);

    // Reset in the 4th SHIFT cycle discards the operation.
    start_op(8'd200, 8'd1, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    rst_n = 1'b1;
    count_valids(W + 4, nv);
    check("midrst_no_valid", 32'(nv), 32'd0);
    directed("0m1", 8'd0, 8'd1, 1'b0, 8'd255, 1'b1, 1'b0, 1'b0);

    // Randomized traffic: back-to-back starts, idle gaps, ignored pulses.
    for (int i = 0; i < 150; i++) begin
      xv = W'($urandom);
      yv = (i % 10 == 0) ? xv : W'($urandom);
      start_op(xv, yv, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        x     = W'($urandom);
        y     = W'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (W + 4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor that computes x − y − borrow_in one bit per clock, LSB first, using a single 1-bit full-subtractor cell and a borrow flip-flop. It is the sequential, inverse-operation counterpart of the combinational ripple adder in the arithmetic library. It sits behind a start/ready/valid handshake, so a controller can trade area for latency.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; accepted only when ready=1.
- x  input  WIDTH  minuend; sampled on the accepting edge.
- y  input  WIDTH  subtrahend; sampled on the accepting edge.
- borrow_in  input  1  incoming borrow; sampled on the accepting edge.
- ready  output  1  idle and able to accept start.
- valid  output  1  one-cycle pulse marking diff/borrow_out as final.
- diff  output  WIDTH  (x − y − borrow_in) mod 2^WIDTH.
- borrow_out  output  1  1 iff x < y + borrow_in, compared unsigned.
- overflow  output  1  signed two's-complement overflow; present only with SERIAL_SUB_FLAGS_EN.
- zero  output  1  diff == 0; present only with SERIAL_SUB_FLAGS_EN.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- IDLE: ready=1.
  - On start=1 it loads shift registers a←x and b←y, loads borrow←borrow_in, and clears bit counter cnt←0.
  - It then goes to SHIFT.
- SHIFT: each cycle does the following.
  - Compute d = a[0]^b[0]^borrow.
  - Compute bnext = (~a[0]&b[0]) | (~(a[0]^b[0])&borrow).
  - Shift a and b right by one.
  - Shift d into the MSB of the result register, so the LSB result lands at bit 0 after WIDTH shifts.
  - Update borrow←bnext and cnt←cnt+1.
  - When cnt==WIDTH−1, go to DONE.
- DONE: valid=1 for exactly one cycle; diff and borrow_out are stable. Next state is IDLE.
- diff and borrow_out hold their last values until the next operation completes. They are not updated visibly mid-operation, because the result register is separate from the output register and the output register loads on the SHIFT→DONE edge.
- start is ignored while ready=0. Back-to-back starts are allowed: start may be high on the cycle DONE→IDLE has just completed.
- cnt width is $clog2(WIDTH). The counter wraps only by FSM exit; it never rolls over in use.
- Reset, whether idle or mid-operation, immediately forces:
  - state = IDLE, ready=1;
  - valid=0, diff=0, borrow_out=0, and with the flags feature overflow=0, zero=0.
  - The in-flight operation is discarded without producing valid.

## Timing
- Accepting edge = E0. SHIFT occupies edges E1..E(WIDTH), and DONE is entered at E(WIDTH).
- valid is high between E(WIDTH) and E(WIDTH+1); ready returns high at E(WIDTH+1).
- Latency from start to valid is WIDTH cycles; throughput is one operation per WIDTH+1 cycles.
- ready goes low at E0 and stays low through DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_SUB_FLAGS_EN defined:
  - overflow and zero ports exist.
  - overflow = x[W−1] ≠ y[W−1] AND diff[W−1] ≠ x[W−1], latched with diff.
  - zero = (diff == 0), latched with diff.
  - MSBs of x and y are captured at E0 for this purpose.
- SERIAL_SUB_FLAGS_EN undefined: the ports and their capture registers are absent. All other behaviour is identical.

## Structure
- Package serial_sub_pkg holds:
  - the state enum typedef (IDLE, SHIFT, DONE);
  - the default WIDTH constant.
- Sub-module full_subtractor is a combinational 1-bit cell:
  - inputs a, b, bin;
  - outputs d, bout.
  - It is instantiated once in the datapath.

## Test plan
- Reset, then 100 − 12 with borrow_in=0 → valid 8 cycles after accept; diff=88, borrow_out=0; ready high the next cycle.
- 99 − 45 with borrow_in=1 → diff=53, borrow_out=0.
- 55 − 127 with borrow_in=0 → diff=184 (8'hB8), borrow_out=1. With flags: overflow=0, zero=0.
- 127 − 127 with borrow_in=1 → diff=255, borrow_out=1. Then 127 − 127 with borrow_in=0 → diff=0, borrow_out=0, zero=1 (flags build).
- 127 − 255 (signed −1) with borrow_in=0 → diff=128, borrow_out=1, overflow=1 (flags build). Also pulse start during SHIFT → ignored; the result is unchanged and there is exactly one valid.
- Start 200 − 1, then assert rst_n=0 at the 4th SHIFT cycle → after the reset edge: ready=1, valid=0, diff=0. No valid appears. A following 0 − 1 yields diff=255, borrow_out=1.
